frame_write_dma: RTL and testbench



---
 rtl/frame_write_dma.sv | 154 +++++++++++++++
 tb/tb_frame_write_dma.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_write_dma.sv
// Packs RGB565 pixel pairs into 32-bit words in a FWFT FIFO and writes fixed-length avl bursts into a wrapping frame buffer.
// A word enters the FIFO 1 cycle after its second pixel; avl_request_ready stalls the burst, and a full FIFO drops words and sets overflow.
module frame_write_dma #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          FRAME_WORDS = 153600,
    parameter int          BURST_LEN   = 64,
    parameter int          FIFO_DEPTH  = 512
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    input  logic        frame_start,
    output logic [31:0] avl_address,
    output logic [3:0]  avl_byte_en,
    output logic        avl_write,
    output logic        avl_read,
    output logic [31:0] avl_write_data,
    output logic        avl_begin_burst_transfer,
    output logic [7:0]  avl_burst_count,
    input  logic        avl_request_ready,
    output logic        busy,
    output logic        overflow,
    output logic        frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_WORDS + 1);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [AW:0]   BURST_CNT   = (AW+1)'(BURST_LEN);
    localparam logic [AW:0]   PTR_ONE     = (AW+1)'(1);
    localparam logic [BW-1:0] LAST_BEAT   = BW'(BURST_LEN - 1);
    localparam logic [BW-1:0] BEAT_ONE    = BW'(1);
    localparam logic [CW-1:0] LAST_START  = CW'(FRAME_WORDS - BURST_LEN);
    localparam logic [CW-1:0] BURST_WORDS = CW'(BURST_LEN);
    localparam logic [31:0]   BURST_BYTES = 32'(4 * BURST_LEN);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr, r_rd_ptr, w_count;
    logic          r_half, r_pack_vld;
    logic [15:0]   r_hi;
    logic [31:0]   r_pack_dat;
    logic [BW-1:0] r_beat;
    logic [CW-1:0] r_words;
    logic [31:0]   r_addr;
    logic          r_flush_pend, r_overflow, r_frame_done;
    logic          w_flush, w_pop, w_last_beat, w_full, w_push, w_pix_ok;

    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_full      = w_count[AW];
    assign w_flush     = (r_state == S_IDLE) && (r_flush_pend || frame_start);
    assign w_pop       = (r_state == S_BURST) && avl_request_ready;
    assign w_last_beat = w_pop && (r_beat == LAST_BEAT);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push      = r_pack_vld && (!w_full || w_pop) && !w_flush;
    assign w_pix_ok    = pix_valid && !r_flush_pend && !frame_start;

    assign avl_address     = r_addr;
    assign avl_byte_en     = 4'hF;
    assign avl_read        = 1'b0;
    assign avl_write_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign avl_burst_count = 8'(BURST_LEN - 1);
    assign overflow        = r_overflow;
    assign frame_done      = r_frame_done;

    always_ff @(posedge clk or posedge rest) begin
        if (rest) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt              = r_state;
        avl_write                = 1'b0;
        avl_begin_burst_transfer = 1'b0;
        busy                     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_flush && (w_count >= BURST_CNT)) w_state_nxt = S_BURST;
            end
            S_BURST: begin
                avl_write                = 1'b1;
                avl_begin_burst_transfer = 1'b1;
                busy                     = 1'b1;
                if (w_last_beat) w_state_nxt = S_GAP;
            end
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_pack_dat;
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            r_half       <= 1'b0;
            r_pack_vld   <= 1'b0;
            r_hi         <= 16'h0;
            r_pack_dat   <= 32'h0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_beat       <= '0;
            r_words      <= '0;
            r_addr       <= BASE_ADDR;
            r_flush_pend <= 1'b0;
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_pack_vld   <= w_pix_ok && r_half;
            r_frame_done <= 1'b0;
            if (w_flush) begin
                r_half <= 1'b0;
            end else if (w_pix_ok) begin
                if (r_half) r_pack_dat <= {r_hi, pix_data};
                else        r_hi       <= pix_data;
                r_half <= !r_half;
            end

            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end

            if (w_flush)                                    r_overflow <= 1'b0;
            else if (r_pack_vld && w_full && !w_pop)        r_overflow <= 1'b1;

            if (w_flush)          r_flush_pend <= 1'b0;
            else if (frame_start) r_flush_pend <= 1'b1;

            if (r_state != S_BURST) r_beat <= '0;
            else if (w_pop)         r_beat <= r_beat + BEAT_ONE;

            if (w_flush) begin
                r_words <= '0;
                r_addr  <= BASE_ADDR;
            end else if (w_last_beat) begin
                if (r_words == LAST_START) begin
                    r_words      <= '0;
                    r_addr       <= BASE_ADDR;
                    r_frame_done <= 1'b1;
                end else begin
                    r_words <= r_words + BURST_WORDS;
                    r_addr  <= r_addr + BURST_BYTES;
                end
            end
        end
    end
endmodule

// File: tb/tb_frame_write_dma.sv
// Scoreboard bench: stimulus pushes expected words, a negedge monitor checks every accepted avl beat.
module tb_frame_write_dma;
    localparam logic [31:0] BASE = 32'h0010_0000;
    localparam int FW = 128;
    localparam int BL = 64;
    localparam int FD = 128;

    logic        clk = 1'b0;
    logic        rest;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        frame_start;
    logic [31:0] avl_address;
    logic [3:0]  avl_byte_en;
    logic        avl_write;
    logic        avl_read;
    logic [31:0] avl_write_data;
    logic        avl_begin_burst_transfer;
    logic [7:0]  avl_burst_count;
    logic        avl_request_ready;
    logic        busy;
    logic        overflow;
    logic        frame_done;

    frame_write_dma #(
        .BASE_ADDR(BASE), .FRAME_WORDS(FW), .BURST_LEN(BL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rest(rest), .pix_valid(pix_valid), .pix_data(pix_data),
        .frame_start(frame_start), .avl_address(avl_address), .avl_byte_en(avl_byte_en),
        .avl_write(avl_write), .avl_read(avl_read), .avl_write_data(avl_write_data),
        .avl_begin_burst_transfer(avl_begin_burst_transfer), .avl_burst_count(avl_burst_count),
        .avl_request_ready(avl_request_ready), .busy(busy), .overflow(overflow),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          acc = 0;
    int          beats_total = 0;
    int          fd_count = 0;
    bit          have_hi = 0;
    logic [15:0] hi_pix = 16'h0;
    int          rdy_mode = 0;
    bit          fd_exp = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_dat = 32'h0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string nm);
        vectors++;
        errors++;
        $display("FAIL timeout %s: condition not reached at %0t", nm, $time);
    endtask

    // Reference model: pixels pair up high-then-low into words.
    task automatic model_pix(input logic [15:0] d);
        if (!have_hi) begin
            hi_pix  = d;
            have_hi = 1;
        end else begin
            exp_q.push_back({hi_pix, d});
            have_hi = 0;
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        acc     = 0;
        have_hi = 0;
    endtask

    task automatic pix(input logic [15:0] d, input bit keep);
        @(posedge clk);
        #1;
        pix_valid = 1'b1;
        pix_data  = d;
        if (keep) model_pix(d);
    endtask

    task automatic pix_off();
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
    endtask

    task automatic wait_beats(input int target, input string nm);
        int n = 0;
        while (beats_total < target && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (beats_total < target) fail_timeout(nm);
    endtask

    task automatic wait_write(input string nm);
        int n = 0;
        while (!avl_write && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (!avl_write) fail_timeout(nm);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || avl_write) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 20000) fail_timeout(nm);
        repeat (4) @(posedge clk);
    endtask

    initial begin
        avl_request_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       avl_request_ready = 1'b0;
                1:       avl_request_ready = 1'b1;
                default: avl_request_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        logic [31:0] ea;
        forever begin
            @(negedge clk);
            if (rest) begin
                fd_exp     = 0;
                prev_stall = 0;
            end else begin
                check("busy", busy, avl_write);
                check("frame_done", frame_done, fd_exp);
                fd_exp = 0;
                if (frame_done) fd_count++;
                if (prev_stall && avl_write) check("stall_hold", avl_write_data, prev_dat);
                if (avl_write && avl_request_ready) begin
                    ea = BASE + 32'(4 * (((acc / BL) * BL) % FW));
                    check("addr", avl_address, ea);
                    check("burst_count", avl_burst_count, BL - 1);
                    check("be_rd_bb", {avl_byte_en, avl_read, avl_begin_burst_transfer}, {4'hF, 1'b0, 1'b1});
                    if (exp_q.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL beat_unexpected: got %h expected no beat at %0t", avl_write_data, $time);
                    end else begin
                        check("wdata", avl_write_data, exp_q.pop_front());
                    end
                    acc++;
                    beats_total++;
                    if (acc % FW == 0) fd_exp = 1;
                end
                prev_stall = avl_write && !avl_request_ready;
                prev_dat   = avl_write_data;
            end
        end
    end

    initial begin
        int b0, f0, n, sent;
        rest = 1'b1; pix_valid = 1'b0; pix_data = 16'h0; frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rest = 1'b0;
        @(negedge clk);
        check("rst_addr", avl_address, BASE);
        check("rst_flags", {avl_write, avl_begin_burst_transfer, busy, overflow, frame_done}, 5'b0);

        // One burst from a counting pixel ramp.
        rdy_mode = 1;
        b0 = beats_total;
        for (int i = 0; i < 128; i++) pix(16'(i + 1), 1);
        pix_off();
        wait_idle("t1");
        check("t1_beats", beats_total - b0, 64);

        // Mid-burst stall; second burst closes the frame.
        b0 = beats_total;
        f0 = fd_count;
        for (int i = 0; i < 128; i++) pix(16'(16'h0100 + i), 1);
        pix_off();
        wait_beats(b0 + 20, "t2_beat20");
        rdy_mode = 0;
        repeat (5) begin
            @(negedge clk);
            check("t2_busy_stall", busy, 1'b1);
        end
        rdy_mode = 1;
        wait_idle("t2");
        check("t2_beats", beats_total - b0, 64);
        check("t2_frame_done_cnt", fd_count - f0, 1);

        // Randomised pixel gaps and slave readiness.
        rdy_mode = 2;
        sent = 0;
        while (sent < 896) begin
            if ($urandom_range(0, 1) == 1) begin
                pix(16'($urandom), 1);
                sent++;
            end else begin
                pix_off();
            end
        end
        pix_off();
        wait_idle("rand");
        check("rand_overflow", overflow, 1'b0);

        // frame_start during a burst.
        rdy_mode = 0;
        b0 = beats_total;
        for (int i = 0; i < 160; i++) pix(16'($urandom), 1);
        pix_off();
        wait_write("t4_write");
        rdy_mode = 1;
        wait_beats(b0 + 10, "t4_beat10");
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        n = 0;
        while (avl_write && n < 200) begin
            pix(16'($urandom), 0);
            n++;
        end
        pix_valid = 1'b0;
        repeat (4) @(posedge clk);
        check("t4_beats", beats_total - b0, 64);
        check("t4_left", exp_q.size(), 16);
        model_flush();
        for (int i = 0; i < 128; i++) pix(16'(16'h4000 + i), 1);
        pix_off();
        wait_idle("t4_next");

        // Overflow with the slave stalled.
        rdy_mode = 0;
        for (int i = 0; i < 2 * FD; i++) pix(16'($urandom), 1);
        pix_off();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t5_no_ovf_yet", overflow, 1'b0);
        pix(16'hAAAA, 0);
        pix(16'h5555, 0);
        pix_off();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t5_ovf_set", overflow, 1'b1);
        rdy_mode = 1;
        wait_idle("t5_drain");
        check("t5_ovf_sticky", overflow, 1'b1);
        @(posedge clk); #1 frame_start = 1'b1; pix_valid = 1'b1; pix_data = 16'hDEAD;
        @(posedge clk); #1 frame_start = 1'b0; pix_valid = 1'b0;
        model_flush();
        @(negedge clk);
        check("t5_ovf_clear", overflow, 1'b0);
        for (int i = 0; i < 128; i++) pix(16'(16'h6000 + i), 1);
        pix_off();
        wait_idle("t5_after");

        // Asynchronous reset mid-burst.
        rdy_mode = 0;
        for (int i = 0; i < 160; i++) pix(16'($urandom), 1);
        pix_off();
        wait_write("t6_write");
        rdy_mode = 1;
        b0 = beats_total;
        wait_beats(b0 + 5, "t6_beat5");
        @(posedge clk);
        #3 rest = 1'b1;
        #1;
        check("t6_write_async", avl_write, 1'b0);
        check("t6_busy_async", busy, 1'b0);
        model_flush();
        repeat (2) @(posedge clk);
        #2 rest = 1'b0;
        @(negedge clk);
        check("t6_addr", avl_address, BASE);
        check("t6_ovf", overflow, 1'b0);
        for (int i = 0; i < 128; i++) pix(16'(16'h7000 + i), 1);
        pix_off();
        wait_idle("t6_after");
        check("t6_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
